// File: rtl/fp_vec_addsub_seq.sv
// fp_vec_addsub_seq: per-element sequencer feeding an FP32 add/sub FU, with zero/denormal bypass
module fp_vec_addsub_seq #(
    parameter int NUM_ELEMS = 8,
    localparam int IDX_W = $clog2(NUM_ELEMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_subtract,
    input  logic [IDX_W:0]   cmd_vl,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [31:0]      rd_a,
    input  logic [31:0]      rd_b,
    output logic [31:0]      fu_a,
    output logic [31:0]      fu_b,
    output logic             fu_subtract,
    input  logic [31:0]      fu_y,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [IDX_W-1:0] wb_idx,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;
    state_t           state;
    logic             sub_q;
    logic [IDX_W:0]   vl_q;
    logic [IDX_W-1:0] idx;
    logic             use_fu;
    logic [31:0]      byp_q;
    logic [IDX_W:0]   vl_in;
    logic             a_zero;
    logic             b_zero;
    logic             last;
    logic [31:0]      b_eff;
    logic [31:0]      byp_d;
    always_comb begin
        vl_in  = cmd_vl > (IDX_W+1)'(NUM_ELEMS) ? (IDX_W+1)'(NUM_ELEMS) : cmd_vl;
        a_zero = rd_a[30:23] == 8'd0;
        b_zero = rd_b[30:23] == 8'd0;
        b_eff  = {rd_b[31] ^ sub_q, rd_b[30:0]};
        byp_d  = a_zero && b_zero ? {rd_a[31] & b_eff[31], 31'b0} : a_zero ? b_eff : rd_a;
        last   = {1'b0, idx} == vl_q - 1'b1;
    end
    // fu operands stay frozen through WRITE, so fu_y is stable while the result is held
    assign wb_data = use_fu ? fu_y : byp_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_idx      <= '0;
            fu_a        <= '0;
            fu_b        <= '0;
            fu_subtract <= 1'b0;
            wb_valid    <= 1'b0;
            wb_idx      <= '0;
            sub_q       <= 1'b0;
            vl_q        <= '0;
            idx         <= '0;
            use_fu      <= 1'b0;
            byp_q       <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    sub_q     <= cmd_subtract;
                    vl_q      <= vl_in;
                    idx       <= '0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= vl_in == '0 ? DONE : READ;
                    done      <= vl_in == '0;
                    rd_en     <= vl_in != '0;
                    rd_idx    <= '0;
                end
                READ: state <= EXEC;
                EXEC: begin
                    fu_a        <= rd_a;
                    fu_b        <= rd_b;
                    fu_subtract <= sub_q;
                    use_fu      <= !a_zero && !b_zero;
                    byp_q       <= byp_d;
                    wb_valid    <= 1'b1;
                    wb_idx      <= idx;
                    state       <= WRITE;
                end
                WRITE: if (wb_ready) begin
                    wb_valid <= 1'b0;
                    state    <= last ? DONE : READ;
                    done     <= last;
                    rd_en    <= !last;
                    rd_idx   <= idx + 1'b1;
                    idx      <= last ? idx : idx + 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
